// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding and fetch constants.
package pc_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StHold    = 2'd2,
        StDiscard = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NopInstr = 32'h0000_0000;
    localparam int unsigned PcIncr   = 4;

endpackage

// File: rtl/pc_fetch_ctrl_skid_buf.sv
// One-entry holding register for an instruction and its pc+4 while IF/ID is stalled.
module pc_fetch_ctrl_skid_buf #(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    pc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter owner: issues imem req/ack fetches, feeds IF/ID under stall, redirects on branch.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int unsigned    PC_W     = 32,
    parameter int unsigned    INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Branch,
    input  logic [PC_W-1:0]    BranchTarget,
    input  logic               Stall,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               IfValid,
    output logic [INSTR_W-1:0] IfInstr,
    output logic [PC_W-1:0]    IfPc,
    output logic               Flush
);

    fetch_state_e       state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pend_q;
    logic               if_valid_q;
    logic [INSTR_W-1:0] if_instr_q;
    logic [PC_W-1:0]    if_pc_q;
    logic               flush_q;

    logic               consume;
    logic [PC_W-1:0]    tgt;
    logic [PC_W-1:0]    pc_inc;
    logic               skid_load;
    logic               skid_clear;
    logic               skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;

    assign consume    = if_valid_q & ~Stall;
    assign tgt        = BranchTarget & ~PC_W'(3);
    assign pc_inc     = pc_q + PC_W'(PcIncr);
    assign skid_load  = (state_q == StReq) & ~Branch & imem_ack & if_valid_q & Stall;
    assign skid_clear = (Branch & (state_q != StIdle)) | ((state_q == StHold) & ~Stall);

    pc_fetch_ctrl_skid_buf #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .instr_i (imem_rdata),
        .pc_i    (pc_inc),
        .valid_o (skid_valid),
        .instr_o (skid_instr),
        .pc_o    (skid_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            if_valid_q <= 1'b0;
            if_instr_q <= INSTR_W'(NopInstr);
            if_pc_q    <= RESET_PC;
            flush_q    <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            // Default drain; any load below overrides it.
            if (consume) begin
                if_valid_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    state_q <= StReq;
                end
                StReq: begin
                    if (Branch) begin
                        flush_q    <= 1'b1;
                        if_valid_q <= 1'b0;
                        if (imem_ack) begin
                            pc_q <= tgt;
                        end else begin
                            pend_q  <= tgt;
                            state_q <= StDiscard;
                        end
                    end else if (imem_ack) begin
                        pc_q <= pc_inc;
                        if (!if_valid_q || !Stall) begin
                            if_valid_q <= 1'b1;
                            if_instr_q <= imem_rdata;
                            if_pc_q    <= pc_inc;
                        end else begin
                            state_q <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (Branch) begin
                        flush_q    <= 1'b1;
                        if_valid_q <= 1'b0;
                        pc_q       <= tgt;
                        state_q    <= StReq;
                    end else if (!Stall) begin
                        if_valid_q <= skid_valid;
                        if_instr_q <= skid_instr;
                        if_pc_q    <= skid_pc;
                        state_q    <= StReq;
                    end
                end
                StDiscard: begin
                    // Wrong-path request stays up until acked; its data is never used.
                    if (Branch) begin
                        flush_q    <= 1'b1;
                        if_valid_q <= 1'b0;
                        pend_q     <= tgt;
                        if (imem_ack) begin
                            pc_q    <= tgt;
                            state_q <= StReq;
                        end
                    end else if (imem_ack) begin
                        pc_q    <= pend_q;
                        state_q <= StReq;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign imem_req  = (state_q == StReq) || (state_q == StDiscard);
    assign imem_addr = pc_q;
    assign IfValid   = if_valid_q;
    assign IfInstr   = if_instr_q;
    assign IfPc      = if_pc_q;
    assign Flush     = flush_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a hand-driven instruction memory.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        Branch;
    logic [31:0] BranchTarget;
    logic        Stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        IfValid;
    logic [31:0] IfInstr;
    logic [31:0] IfPc;
    logic        Flush;

    int n_tests;
    int n_fail;

    pc_fetch_ctrl #(
        .PC_W     (32),
        .INSTR_W  (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Branch       (Branch),
        .BranchTarget (BranchTarget),
        .Stall        (Stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .IfValid      (IfValid),
        .IfInstr      (IfInstr),
        .IfPc         (IfPc),
        .Flush        (Flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; Branch = 1'b0; BranchTarget = '0; Stall = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        tick(); tick();
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        n_tests++; if (IfValid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", IfValid); end
        n_tests++; if (IfInstr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", IfInstr); end
        n_tests++; if (IfPc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", IfPc); end
        n_tests++; if (Flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b want 0", Flush); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_addr;
        rst_n = 1'b1;
        tick();
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL zw_first_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
        n_tests++; if (IfValid !== 1'b0) begin n_fail++; $display("FAIL zw_no_valid_yet: got %b want 0", IfValid); end
        imem_ack = 1'b1;
        exp_addr = 32'h0;
        for (int i = 0; i < 4; i++) begin
            imem_rdata = 32'hA000_0000 | exp_addr;
            tick();
            exp_addr = exp_addr + 32'd4;
            n_tests++; if (IfValid !== 1'b1 || IfPc !== exp_addr) begin n_fail++; $display("FAIL zw_deliver%0d: got valid=%b pc=%h want 1/%h", i, IfValid, IfPc, exp_addr); end
            n_tests++; if (IfInstr !== (32'hA000_0000 | (exp_addr - 32'd4))) begin n_fail++; $display("FAIL zw_instr%0d: got %h want %h", i, IfInstr, 32'hA000_0000 | (exp_addr - 32'd4)); end
            n_tests++; if (imem_addr !== exp_addr || Flush !== 1'b0) begin n_fail++; $display("FAIL zw_addr%0d: got addr=%h flush=%b want %h/0", i, imem_addr, Flush, exp_addr); end
        end
    endtask

    task automatic test_wait2();
        imem_ack = 1'b0;
        tick();
        n_tests++; if (IfValid !== 1'b0) begin n_fail++; $display("FAIL w2_drain: got %b want 0", IfValid); end
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL w2_hold1: got req=%b addr=%h want 1/10", imem_req, imem_addr); end
        tick();
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || IfValid !== 1'b0) begin n_fail++; $display("FAIL w2_hold2: got req=%b addr=%h valid=%b want 1/10/0", imem_req, imem_addr, IfValid); end
        imem_ack = 1'b1; imem_rdata = 32'hB000_0010;
        tick();
        n_tests++; if (IfValid !== 1'b1 || IfInstr !== 32'hB000_0010 || IfPc !== 32'h14) begin n_fail++; $display("FAIL w2_deliver: got %b/%h/%h want 1/b0000010/14", IfValid, IfInstr, IfPc); end
        imem_ack = 1'b0;
        tick();
        n_tests++; if (IfValid !== 1'b0 || imem_addr !== 32'h14) begin n_fail++; $display("FAIL w2_once: got valid=%b addr=%h want 0/14", IfValid, imem_addr); end
    endtask

    task automatic test_stall();
        imem_ack = 1'b1; imem_rdata = 32'hC000_0014;
        tick();
        n_tests++; if (IfValid !== 1'b1 || IfInstr !== 32'hC000_0014 || IfPc !== 32'h18) begin n_fail++; $display("FAIL st_pre: got %b/%h/%h want 1/c0000014/18", IfValid, IfInstr, IfPc); end
        Stall = 1'b1; imem_rdata = 32'hC000_0018;
        tick();
        imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL st_hold_req: got %b want 0", imem_req); end
        n_tests++; if (IfInstr !== 32'hC000_0014 || IfPc !== 32'h18 || IfValid !== 1'b1) begin n_fail++; $display("FAIL st_hold_out: got %b/%h/%h want 1/c0000014/18", IfValid, IfInstr, IfPc); end
        tick(); tick();
        n_tests++; if (imem_req !== 1'b0 || IfInstr !== 32'hC000_0014) begin n_fail++; $display("FAIL st_hold3: got req=%b instr=%h want 0/c0000014", imem_req, IfInstr); end
        Stall = 1'b0;
        tick();
        n_tests++; if (IfValid !== 1'b1 || IfInstr !== 32'hC000_0018 || IfPc !== 32'h1C) begin n_fail++; $display("FAIL st_skid_out: got %b/%h/%h want 1/c0000018/1c", IfValid, IfInstr, IfPc); end
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h1C) begin n_fail++; $display("FAIL st_resume: got req=%b addr=%h want 1/1c", imem_req, imem_addr); end
        tick();
        n_tests++; if (IfValid !== 1'b0) begin n_fail++; $display("FAIL st_drain: got %b want 0", IfValid); end
    endtask

    task automatic test_branch_ack();
        imem_ack = 1'b1; imem_rdata = 32'hD000_001C;
        tick();
        n_tests++; if (IfValid !== 1'b1 || IfPc !== 32'h20) begin n_fail++; $display("FAIL br_pre: got %b/%h want 1/20", IfValid, IfPc); end
        Branch = 1'b1; BranchTarget = 32'h40; Stall = 1'b1; imem_rdata = 32'hBAD0_0020;
        tick();
        n_tests++; if (Flush !== 1'b1) begin n_fail++; $display("FAIL br_flush: got %b want 1", Flush); end
        n_tests++; if (IfValid !== 1'b0 || IfInstr !== 32'hD000_001C) begin n_fail++; $display("FAIL br_drop: got %b/%h want 0/d000001c", IfValid, IfInstr); end
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL br_redirect: got req=%b addr=%h want 1/40", imem_req, imem_addr); end
        Branch = 1'b0; Stall = 1'b0; imem_ack = 1'b0;
        tick();
        n_tests++; if (Flush !== 1'b0 || IfValid !== 1'b0 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL br_after: got flush=%b valid=%b addr=%h want 0/0/40", Flush, IfValid, imem_addr); end
    endtask

    task automatic test_discard();
        Branch = 1'b1; BranchTarget = 32'h20; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0040;
        tick();
        n_tests++; if (Flush !== 1'b1 || imem_addr !== 32'h20) begin n_fail++; $display("FAIL ds_setup: got flush=%b addr=%h want 1/20", Flush, imem_addr); end
        BranchTarget = 32'h80; imem_ack = 1'b0;
        tick();
        n_tests++; if (Flush !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h20) begin n_fail++; $display("FAIL ds_br1: got flush=%b req=%b addr=%h want 1/1/20", Flush, imem_req, imem_addr); end
        Branch = 1'b0;
        tick();
        n_tests++; if (Flush !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h20) begin n_fail++; $display("FAIL ds_gap: got flush=%b req=%b addr=%h want 0/1/20", Flush, imem_req, imem_addr); end
        Branch = 1'b1; BranchTarget = 32'hC3;
        tick();
        n_tests++; if (Flush !== 1'b1 || imem_addr !== 32'h20) begin n_fail++; $display("FAIL ds_br2: got flush=%b addr=%h want 1/20", Flush, imem_addr); end
        Branch = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0020;
        tick();
        n_tests++; if (Flush !== 1'b0 || IfValid !== 1'b0) begin n_fail++; $display("FAIL ds_drop: got flush=%b valid=%b want 0/0", Flush, IfValid); end
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'hC0) begin n_fail++; $display("FAIL ds_target: got req=%b addr=%h want 1/c0", imem_req, imem_addr); end
        imem_rdata = 32'hE000_00C0;
        tick();
        n_tests++; if (IfValid !== 1'b1 || IfInstr !== 32'hE000_00C0 || IfPc !== 32'hC4) begin n_fail++; $display("FAIL ds_fetch: got %b/%h/%h want 1/e00000c0/c4", IfValid, IfInstr, IfPc); end
    endtask

    task automatic test_reset_discard();
        Branch = 1'b1; BranchTarget = 32'h100; imem_ack = 1'b0;
        tick();
        n_tests++; if (Flush !== 1'b1 || imem_addr !== 32'hC4 || imem_req !== 1'b1) begin n_fail++; $display("FAIL rd_enter: got flush=%b req=%b addr=%h want 1/1/c4", Flush, imem_req, imem_addr); end
        Branch = 1'b0; rst_n = 1'b0;
        tick();
        n_tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || Flush !== 1'b0) begin n_fail++; $display("FAIL rd_rst: got req=%b addr=%h flush=%b want 0/0/0", imem_req, imem_addr, Flush); end
        n_tests++; if (IfValid !== 1'b0 || IfInstr !== 32'h0 || IfPc !== 32'h0) begin n_fail++; $display("FAIL rd_rst_out: got %b/%h/%h want 0/0/0", IfValid, IfInstr, IfPc); end
        rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_00C4;
        tick();
        n_tests++; if (IfValid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rd_late_ack: got valid=%b req=%b addr=%h want 0/1/0", IfValid, imem_req, imem_addr); end
        imem_rdata = 32'hF000_0000;
        tick();
        n_tests++; if (IfValid !== 1'b1 || IfInstr !== 32'hF000_0000 || IfPc !== 32'h4) begin n_fail++; $display("FAIL rd_restart: got %b/%h/%h want 1/f0000000/4", IfValid, IfInstr, IfPc); end
        imem_ack = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_zero_wait();
        test_wait2();
        test_stall();
        test_branch_ack();
        test_discard();
        test_reset_discard();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Consumes the Branch/target decision from the branch control unit and owns the program counter.
- Issues instruction-memory requests over a req/ack handshake and delivers fetched instructions to the IF/ID pipeline register under hazard-unit stall.
- On a taken branch, redirects fetch, squashes the wrong-path fetch already in flight, and raises a one-cycle Flush for the later stages.

Parameters:
- PC_W, 32, program counter and address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, first fetch address after reset. Low two bits are zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- Branch  in  1  taken-branch/jump request from branch control.
- BranchTarget  in  PC_W  redirect address, valid while Branch=1.
- Stall  in  1  hazard unit: IF/ID must hold its current contents.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  PC_W  fetch address, word aligned.
- imem_ack  in  1  memory returns imem_rdata this cycle; may coincide with the first req cycle.
- imem_rdata  in  INSTR_W  fetched instruction.
- IfValid  out  1  IfInstr/IfPc hold a valid instruction.
- IfInstr  out  INSTR_W  instruction to decode.
- IfPc  out  PC_W  address of IfInstr plus 4.
- Flush  out  1  squash younger stages; registered, one cycle.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - IfValid=0, IfInstr=0 (NOP), IfPc=RESET_PC, Flush=0.
  - The skid buffer and the pending target are cleared.
  - Reset mid-handshake abandons the request. A late ack in IDLE is ignored.
- "consume" = IfValid & ~Stall. When consume=1 and no new data is loaded, IfValid falls to 0 at the next edge.
- States:
  - IDLE: imem_req=0. Moves to REQ on the next edge.
  - REQ: imem_req=1 and imem_addr=pc, both stable until ack.
    - On ack with Branch=0 and output slot free (IfValid=0 or consume): IfInstr<=rdata, IfPc<=pc+4, IfValid<=1, pc<=pc+4, stay in REQ.
    - On ack with output slot busy (IfValid & Stall): rdata goes into the skid buffer with pc+4, pc<=pc+4, next state HOLD.
  - HOLD: imem_req=0. When Stall=0, the skid buffer loads into the outputs (IfValid stays 1) and the next state is REQ.
  - DISCARD: imem_req stays 1 at the old address. The wrong-path request cannot be withdrawn. On ack, the data is dropped, pc<=pending target, and the next state is REQ.
- Branch handling (Branch has priority over Stall and over ack data):
  - Any state except IDLE: at the edge, IfValid<=0, the skid buffer is invalidated, and Flush<=1 for exactly one cycle.
  - REQ with ack=1: rdata is dropped, pc<=target, stay in REQ.
  - REQ with ack=0: target is latched as pending, next state DISCARD.
  - HOLD: pc<=target, next state REQ.
  - DISCARD: the newer target overwrites the pending target (last branch wins).
  - IDLE: Branch is ignored (reset recovery).
- Arithmetic: BranchTarget[1:0] is forced to 00. pc+4 wraps modulo 2^PC_W.
- Throughput: with a zero-wait memory (ack in the req cycle), one instruction per cycle. Fetch-to-IfValid latency is 1 edge after ack.

Decomposition:
- Shared package: fetch state encoding (IDLE, REQ, HOLD, DISCARD), NOP constant, PC increment constant 4.
- Natural sub-module: fetch_skid_buf, a one-entry holding register for instruction + pc with valid.

Test Plan:
- Reset release, zero-wait memory, RESET_PC=0 -> imem_addr 0,4,8 on consecutive cycles. IfValid rises one edge after the first ack with IfPc=4. Flush stays 0.
- Memory with 2-cycle ack latency at addr 0x10 -> imem_req and imem_addr=0x10 held stable for 2 cycles. Exactly one instruction delivered per ack.
- Stall=1 for 3 cycles while IfValid=1 and an ack arrives -> data captured in skid, state HOLD, req low. IfInstr unchanged. On Stall=0 the skid data appears next edge, then fetch resumes at pc+4.
- Branch=1, target 0x40, in REQ with ack same cycle -> fetched data dropped, next imem_addr=0x40, Flush high exactly one cycle, IfValid=0.
- Branch target 0x80 while a 3-cycle request at 0x20 is pending, then a second Branch to 0xC3 before ack -> ack at 0x20 discarded, next fetch at 0xC0, Flush pulses once per branch.
- rst_n=0 during DISCARD followed by a late ack -> outputs at reset values, ack ignored, fetch restarts at RESET_PC.
